lnic_net_tx_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing the single NIC TX stream (net_out_*)

---
 rtl/lnic_net_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_lnic_net_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lnic_net_tx_arbiter.sv
// Packet-granular round-robin arbiter merging NumIn TX streams onto one NIC stream.
// Optional statistics counters are enabled by defining LNIC_TX_ARB_STATS_EN.
module lnic_net_tx_arbiter #(
  parameter int unsigned NumIn = 2,
  parameter int unsigned DataW = 64,
  parameter int unsigned KeepW = 8,
  parameter int unsigned CntW  = 32,
  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumIn-1:0]       in_valid_i,
  output logic [NumIn-1:0]       in_ready_o,
  input  logic [NumIn*DataW-1:0] in_bits_data_i,
  input  logic [NumIn*KeepW-1:0] in_bits_keep_i,
  input  logic [NumIn-1:0]       in_bits_last_i,
  output logic                   net_out_valid_o,
  input  logic                   net_out_ready_i,
  output logic [DataW-1:0]       net_out_bits_data_o,
  output logic [KeepW-1:0]       net_out_bits_keep_o,
  output logic                   net_out_bits_last_o,
  output logic [IdxW-1:0]        grant_idx_o,
  output logic                   busy_o,
  input  logic                   stats_clear_i,
  output logic [CntW-1:0]        stats_pkt_cnt_o,
  output logic [CntW-1:0]        stats_beat_cnt_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  logic [DataW-1:0] lane_data [NumIn];
  logic [KeepW-1:0] lane_keep [NumIn];

  for (genvar g = 0; g < NumIn; g++) begin : gen_lane
    assign lane_data[g] = in_bits_data_i[g*DataW +: DataW];
    assign lane_keep[g] = in_bits_keep_i[g*KeepW +: KeepW];
  end

  // Round-robin search starting at rr_ptr_q.
  logic            arb_found;
  logic [IdxW-1:0] arb_pick;
  int unsigned     arb_sum;

  always_comb begin
    arb_found = 1'b0;
    arb_pick  = rr_ptr_q;
    arb_sum   = 0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      arb_sum = 32'(rr_ptr_q) + k;
      if (arb_sum >= NumIn) arb_sum = arb_sum - NumIn;
      if (!arb_found && in_valid_i[arb_sum[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_pick  = arb_sum[IdxW-1:0];
      end
    end
  end

  logic xfer;

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    rr_ptr_d            = rr_ptr_q;
    in_ready_o          = '0;
    net_out_valid_o     = 1'b0;
    net_out_bits_data_o = '0;
    net_out_bits_keep_o = '0;
    net_out_bits_last_o = 1'b0;
    xfer                = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_d = arb_pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        net_out_valid_o       = in_valid_i[grant_q];
        net_out_bits_data_o   = lane_data[grant_q];
        net_out_bits_keep_o   = lane_keep[grant_q];
        net_out_bits_last_o   = in_bits_last_i[grant_q];
        in_ready_o[grant_q]   = net_out_ready_i;
        xfer                  = in_valid_i[grant_q] & net_out_ready_i;
        if (xfer && in_bits_last_i[grant_q]) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == IdxW'(NumIn - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_idx_o = grant_q;
  assign busy_o      = (state_q == StBusy);

`ifdef LNIC_TX_ARB_STATS_EN
  logic [CntW-1:0] pkt_cnt_q, beat_cnt_q;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else if (stats_clear_i) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else if (xfer) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
      if (net_out_bits_last_o) pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end

  assign stats_pkt_cnt_o  = pkt_cnt_q;
  assign stats_beat_cnt_o = beat_cnt_q;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear_i;
  assign stats_pkt_cnt_o    = '0;
  assign stats_beat_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_lnic_net_tx_arbiter.sv
// Scoreboard bench for lnic_net_tx_arbiter (NumIn=2); stats checks depend on
// LNIC_TX_ARB_STATS_EN.
module tb_lnic_net_tx_arbiter;

  logic         clk, rst;
  logic [1:0]   in_valid, in_last, in_ready;
  logic [127:0] in_data;
  logic [15:0]  in_keep;
  logic         net_out_valid, net_out_ready, net_out_last;
  logic [63:0]  net_out_data;
  logic [7:0]   net_out_keep;
  logic         grant_idx, busy, stats_clear;
  logic [31:0]  stats_pkt, stats_beat;

  int n_checks = 0;
  int n_errs   = 0;

  logic [72:0] exp_q0[$];
  logic [72:0] exp_q1[$];
  int          grant_log[$];
  bit          ready_mode = 1'b0;

  lnic_net_tx_arbiter #(.NumIn(2), .DataW(64), .KeepW(8), .CntW(32)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_bits_data_i(in_data), .in_bits_keep_i(in_keep), .in_bits_last_i(in_last),
    .net_out_valid_o(net_out_valid), .net_out_ready_i(net_out_ready),
    .net_out_bits_data_o(net_out_data), .net_out_bits_keep_o(net_out_keep),
    .net_out_bits_last_o(net_out_last),
    .grant_idx_o(grant_idx), .busy_o(busy),
    .stats_clear_i(stats_clear), .stats_pkt_cnt_o(stats_pkt), .stats_beat_cnt_o(stats_beat)
  );

`ifdef LNIC_TX_ARB_STATS_EN
  logic [1:0]  n_in_ready;
  logic        n_valid, n_last, n_grant, n_busy;
  logic [63:0] n_data;
  logic [7:0]  n_keep;
  logic [3:0]  n_pkt, n_beat;

  lnic_net_tx_arbiter #(.NumIn(2), .DataW(64), .KeepW(8), .CntW(4)) u_dut_narrow (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(n_in_ready),
    .in_bits_data_i(in_data), .in_bits_keep_i(in_keep), .in_bits_last_i(in_last),
    .net_out_valid_o(n_valid), .net_out_ready_i(net_out_ready),
    .net_out_bits_data_o(n_data), .net_out_bits_keep_o(n_keep),
    .net_out_bits_last_o(n_last),
    .grant_idx_o(n_grant), .busy_o(n_busy),
    .stats_clear_i(stats_clear), .stats_pkt_cnt_o(n_pkt), .stats_beat_cnt_o(n_beat)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for in_ready[src] with the lane already presented; returns on the accepting edge.
  task automatic wait_accept(input int src, output bit ok);
    int waited = 0;
    ok = 1'b0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready[src]) ok = 1'b1;
      else waited++;
    end
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input int src, input int nbeats, input logic [63:0] base, input bit gaps);
    logic [63:0] d;
    logic [7:0]  k;
    bit          ok;
    for (int b = 0; b < nbeats; b++) begin
      d = base * 64'(b + 1);
      k = 8'hFF >> b;
      if (src == 0) exp_q0.push_back({b == nbeats - 1, k, d});
      else          exp_q1.push_back({b == nbeats - 1, k, d});
    end
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid[src] = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid[src]           = 1'b1;
      in_data[src*64 +: 64]   = base * 64'(b + 1);
      in_keep[src*8 +: 8]     = 8'hFF >> b;
      in_last[src]            = (b == nbeats - 1);
      wait_accept(src, ok);
      if (!ok) break;
    end
    in_valid[src] = 1'b0;
    in_last[src]  = 1'b0;
  endtask

  // Scoreboard monitor: compares accepted beats, checks idle gaps and lane gating.
  bit chk_gap = 1'b0;
  initial begin
    logic [72:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk_gap = 1'b0;
      end else begin
        if (chk_gap) begin
          chk("idle_after_last", busy, 1'b0);
          chk_gap = 1'b0;
        end
        if (busy) begin
          chk("ready_granted", in_ready[grant_idx], net_out_ready);
          chk("ready_other", in_ready[~grant_idx], 1'b0);
          if (net_out_valid && net_out_ready) begin
            if ((grant_idx ? exp_q1.size() : exp_q0.size()) == 0) begin
              chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
              exp = grant_idx ? exp_q1.pop_front() : exp_q0.pop_front();
              chk("beat", {net_out_last, net_out_keep, net_out_data}, exp);
            end
            if (net_out_last) begin
              grant_log.push_back(int'(grant_idx));
              chk_gap = 1'b1;
            end
          end
        end else begin
          chk("idle_outputs", {in_ready, net_out_valid, net_out_last, net_out_keep, net_out_data},
              '0);
        end
      end
    end
  end

  initial begin
    net_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      net_out_ready = ready_mode ? ~net_out_ready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  bit t4_done;
  bit ok;

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; in_keep = '0; stats_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", net_out_valid, 1'b0);
    chk("rst_ready", in_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_grant", grant_idx, 1'b0);

    // 3-beat packet on in0: one arbitration cycle, then beats 0x11,0x22,0x33
    @(posedge clk);
    #1;
    fork
      send_pkt(0, 3, 64'h11, 1'b0);
      begin
        @(negedge clk);
        chk("arb_cycle_busy", busy, 1'b0);
        chk("arb_cycle_valid", net_out_valid, 1'b0);
        @(negedge clk);
        chk("first_beat_busy", busy, 1'b1);
        chk("first_beat_data", net_out_data, 64'h11);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // bring rr_ptr back to 0, then both stream 2-beat packets continuously
    send_pkt(1, 1, 64'h7, 1'b0);
    grant_log.delete();
    fork
      begin
        send_pkt(0, 2, 64'h100, 1'b0);
        send_pkt(0, 2, 64'h200, 1'b0);
      end
      begin
        send_pkt(1, 2, 64'h300, 1'b0);
        send_pkt(1, 2, 64'h400, 1'b0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 2);

    // in1 packet with backpressure toggling and valid gaps
    ready_mode = 1'b1;
    t4_done = 1'b0;
    fork
      begin
        send_pkt(1, 5, 64'h4040, 1'b1);
        t4_done = 1'b1;
      end
      begin
        while (!t4_done) begin
          @(negedge clk);
          if (busy) begin
            chk("bp_grant", grant_idx, 1'b1);
            chk("bp_in0_ready", in_ready[0], 1'b0);
          end
        end
      end
    join
    ready_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // in0 completes (rr_ptr=1), then in1 is reset after 2 of 4 beats
    send_pkt(0, 1, 64'h55, 1'b0);
    exp_q1.push_back({1'b0, 8'hFF, 64'hA1});
    exp_q1.push_back({1'b0, 8'hFF, 64'hA2});
    in_valid[1] = 1'b1; in_data[127:64] = 64'hA1; in_keep[15:8] = 8'hFF; in_last[1] = 1'b0;
    wait_accept(1, ok);
    in_data[127:64] = 64'hA2;
    wait_accept(1, ok);
    in_data[127:64] = 64'hA3;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", net_out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", net_out_data, 64'h0);
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    grant_log.delete();
    fork
      send_pkt(0, 1, 64'h61, 1'b0);
      send_pkt(1, 1, 64'h71, 1'b0);
    join
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_count", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("post_rst_first", grant_log[0], 0);

`ifdef LNIC_TX_ARB_STATS_EN
    stats_clear = 1'b1;
    @(posedge clk);
    #1;
    stats_clear = 1'b0;
    for (int p = 0; p < 5; p++) send_pkt(p % 2, 4, 64'h1000 * 64'(p + 1), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("stats_pkt5", stats_pkt, 32'd5);
    chk("stats_beat20", stats_beat, 32'd20);
    chk("narrow_pkt5", n_pkt, 4'd5);
    chk("narrow_beat20", n_beat, 4'd4);
    fork
      send_pkt(0, 2, 64'hC0, 1'b0);
      begin
        int w = 0;
        bit seen = 1'b0;
        while (!seen && w < 50) begin
          @(negedge clk);
          if (net_out_valid && net_out_ready && net_out_last) seen = 1'b1;
          else w++;
        end
        stats_clear = 1'b1;
        @(posedge clk);
        #1;
        stats_clear = 1'b0;
      end
    join
    chk("clear_wins_pkt", stats_pkt, 32'd0);
    chk("clear_wins_beat", stats_beat, 32'd0);
    for (int p = 0; p < 17; p++) send_pkt(0, 1, 64'(p + 1), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("stats_pkt17", stats_pkt, 32'd17);
    chk("narrow_wrap_pkt", n_pkt, 4'd1);
    chk("narrow_wrap_beat", n_beat, 4'd1);
`else
    stats_clear = 1'b1;
    @(posedge clk);
    #1;
    stats_clear = 1'b0;
    chk("stats_off_pkt", stats_pkt, 32'd0);
    chk("stats_off_beat", stats_beat, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
